// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl: single-word request initiator for one Memory port.
// Accepts a read or write request and drives the memory strobes, address and data.
// Waits out the memory's fixed read latency, captures the read data and pulses rsp_valid.
module mem_request_ctrl #(
  parameter int unsigned STALL     = 2,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  inout  wire  [WORD_SIZE-1:0] mem_data,
  output logic [WORD_SIZE-1:0] stall_cycles
);

  localparam int unsigned CNT_W = (STALL + 2 > 2) ? $clog2(STALL + 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL + 1);
  localparam logic [WORD_SIZE-1:0] STALL_MAX = {WORD_SIZE{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] stall_q, stall_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;

  // State and registered outputs; synchronous active-low reset aborts any transaction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      stall_q     <= '0;
      rsp_valid_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      stall_q     <= stall_d;
      rsp_valid_q <= rsp_valid_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Next-state and next-output logic; strobes are set on entry so they come straight from flops
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    stall_d     = stall_q;
    rsp_valid_d = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
          end else begin
            state_d    = READ;
            cnt_d      = '0;
            mem_read_d = 1'b1;
          end
        end
      end
      READ: begin
        cnt_d   = cnt_q + CNT_W'(1);
        stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + WORD_SIZE'(1);
        if (cnt_q == CNT_LAST) begin
          rdata_d     = mem_data;
          state_d     = DONE;
          mem_read_d  = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      WRITE: begin
        state_d     = DONE;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = addr_q;
  assign stall_cycles = stall_q;

  // Bus is driven only while the write is presented
  assign mem_data = (state_q == WRITE) ? wdata_q : {WORD_SIZE{1'bz}};

endmodule
